// File: rtl/life_row_stepper.sv
// Streams one Game-of-Life generation row by row through a 3-row sliding window.
// The vertical edges are dead. The horizontal edges wrap or are dead, selected by WRAP_X.
module life_row_stepper #(
    parameter int W      = 8,
    parameter int H      = 8,
    parameter int WRAP_X = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_row,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_row,
    output logic         out_last,
    output logic         busy
);

    localparam int CW = (H < 2) ? 1 : $clog2(H + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRST,
        S_RUN,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t        state_reg, state_next;
    logic [W-1:0]  prev_reg, prev_next;
    logic [W-1:0]  cur_reg, cur_next;
    logic [W-1:0]  out_row_reg, out_row_next;
    logic [CW-1:0] in_cnt_reg, in_cnt_next;
    logic          out_valid_reg, out_valid_next;
    logic          out_last_reg, out_last_next;
    logic          busy_reg, busy_next;

    logic          slot_free;
    logic          in_fire;
    logic          out_fire;
    logic [W-1:0]  below_row;
    logic [W-1:0]  life_row;
    logic [W+1:0]  above_ext, mid_ext, below_ext;

    assign slot_free = !out_valid_reg || out_ready;
    assign in_ready  = ((state_reg == S_FIRST) || (state_reg == S_RUN)) && slot_free;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_reg && out_ready;

    // The last row sees a dead row below it, so FLUSH replaces the incoming row with zeros.
    assign below_row = (state_reg == S_FLUSH) ? '0 : in_row;

    // Each row gets one extra cell on both sides. Those cells hold the wrapped neighbour, or 0 when the edge is dead.
    assign above_ext = {(WRAP_X != 0) ? prev_reg[0]  : 1'b0, prev_reg,
                        (WRAP_X != 0) ? prev_reg[W-1] : 1'b0};
    assign mid_ext   = {(WRAP_X != 0) ? cur_reg[0]   : 1'b0, cur_reg,
                        (WRAP_X != 0) ? cur_reg[W-1]  : 1'b0};
    assign below_ext = {(WRAP_X != 0) ? below_row[0] : 1'b0, below_row,
                        (WRAP_X != 0) ? below_row[W-1] : 1'b0};

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_cell
            logic [3:0] n;
            assign n = {3'b000, above_ext[gi]} + {3'b000, above_ext[gi+1]} + {3'b000, above_ext[gi+2]}
                     + {3'b000, mid_ext[gi]}                                 + {3'b000, mid_ext[gi+2]}
                     + {3'b000, below_ext[gi]} + {3'b000, below_ext[gi+1]} + {3'b000, below_ext[gi+2]};
            assign life_row[gi] = (n == 4'd3) || (mid_ext[gi+1] && (n == 4'd2));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            prev_reg      <= '0;
            cur_reg       <= '0;
            out_row_reg   <= '0;
            in_cnt_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            prev_reg      <= prev_next;
            cur_reg       <= cur_next;
            out_row_reg   <= out_row_next;
            in_cnt_reg    <= in_cnt_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
            busy_reg      <= busy_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        prev_next      = prev_reg;
        cur_next       = cur_reg;
        out_row_next   = out_row_reg;
        in_cnt_next    = in_cnt_reg;
        out_valid_next = out_valid_reg;
        out_last_next  = out_last_reg;
        busy_next      = busy_reg;

        // A consumed output frees the slot. A new row loaded in the same cycle overrides this below.
        if (out_fire) begin
            out_valid_next = 1'b0;
        end

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next  = S_FIRST;
                    prev_next   = '0;
                    in_cnt_next = '0;
                    busy_next   = 1'b1;
                end
            end
            S_FIRST: begin
                if (in_fire) begin
                    cur_next    = in_row;
                    in_cnt_next = CW'(1);
                    state_next  = (H == 1) ? S_FLUSH : S_RUN;
                end
            end
            S_RUN: begin
                if (in_fire) begin
                    out_row_next   = life_row;
                    out_valid_next = 1'b1;
                    out_last_next  = 1'b0;
                    prev_next      = cur_reg;
                    cur_next       = in_row;
                    in_cnt_next    = in_cnt_reg + CW'(1);
                    if (in_cnt_reg == CW'(H - 1)) begin
                        state_next = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (slot_free) begin
                    out_row_next   = life_row;
                    out_valid_next = 1'b1;
                    out_last_next  = 1'b1;
                    state_next     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_fire && out_last_reg) begin
                    state_next    = S_IDLE;
                    out_last_next = 1'b0;
                    busy_next     = 1'b0;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign out_valid = out_valid_reg;
    assign out_row   = out_row_reg;
    assign out_last  = out_last_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_life_row_stepper.sv
// Drives whole generations into two steppers (wrapping and dead edges) with identical stimulus.
// Each output row is checked against a cell-by-cell neighbour-count model.
module tb_life_row_stepper;

    localparam int W = 8;
    localparam int H = 8;

    typedef logic [W-1:0] grid_t [H];

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_row = '0;
    logic         out_ready = 1'b0;

    logic         in_ready_a, out_valid_a, out_last_a, busy_a;
    logic [W-1:0] out_row_a;
    logic         in_ready_b, out_valid_b, out_last_b, busy_b;
    logic [W-1:0] out_row_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    life_row_stepper #(.W(W), .H(H), .WRAP_X(1)) dut_a (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_row(in_row),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_row(out_row_a),
        .out_last(out_last_a), .busy(busy_a)
    );

    life_row_stepper #(.W(W), .H(H), .WRAP_X(0)) dut_b (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_row(in_row),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_row(out_row_b),
        .out_last(out_last_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next generation from the rules: count the live cells among the 8 neighbours, wrap columns optionally, rows outside are dead.
    function automatic grid_t life_model(input grid_t g, input bit wrap);
        grid_t r;
        for (int row = 0; row < H; row++) begin
            for (int col = 0; col < W; col++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr, cc;
                        rr = row + dr;
                        cc = col + dc;
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < H) begin
                            if (wrap) cc = (cc + W) % W;
                            if (cc >= 0 && cc < W) n += int'(g[rr][cc]);
                        end
                    end
                end
                r[row][col] = (n == 3) || (g[row][col] && n == 2);
            end
        end
        return r;
    endfunction

    task automatic run_gen(input grid_t g, input bit bp, input bit noise, input string name);
        grid_t ea, eb;
        int in_idx, out_idx, cyc, first_in, last_in;
        bit held, in_hs, out_hs;
        logic [W-1:0] held_row;
        logic held_last;
        ea = life_model(g, 1'b1);
        eb = life_model(g, 1'b0);
        in_idx = 0; out_idx = 0; cyc = 0; first_in = -1; last_in = -1; held = 0;
        held_row = '0; held_last = 1'b0;
        @(negedge clk);
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        while (out_idx < H && cyc < 300) begin
            in_valid  = (in_idx < H);
            in_row    = (in_idx < H) ? g[in_idx] : W'($urandom);
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            if (held) begin
                chk({name, "_stall_valid"}, out_valid_a, 1);
                chk({name, "_stall_row"}, out_row_a, held_row);
                chk({name, "_stall_last"}, out_last_a, held_last);
            end
            held = 0;
            if (out_valid_a && !out_ready) begin
                chk({name, "_stall_in_ready"}, in_ready_a, 0);
                held = 1; held_row = out_row_a; held_last = out_last_a;
            end
            in_hs  = in_valid && in_ready_a;
            out_hs = out_valid_a && out_ready;
            if (out_hs) begin
                chk($sformatf("%s_row%0d_wrap", name, out_idx), out_row_a, ea[out_idx]);
                chk($sformatf("%s_row%0d_dead", name, out_idx), out_row_b, eb[out_idx]);
                chk($sformatf("%s_last%0d", name, out_idx), out_last_a, (out_idx == H - 1));
                chk($sformatf("%s_valid_b%0d", name, out_idx), out_valid_b, 1);
            end
            @(posedge clk);
            if (in_hs) begin
                if (in_idx == 0) first_in = cyc;
                in_idx++;
                if (in_idx == H) last_in = cyc;
            end
            if (out_hs) out_idx++;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk({name, "_rows_out"}, out_idx, H);
        if (!bp) chk({name, "_throughput"}, last_in - first_in, H - 1);
        #1;
        chk({name, "_busy_done"}, busy_a, 0);
        chk({name, "_valid_done"}, out_valid_a, 0);
        $display("gen %s: %0d rows in, %0d rows out, %0d cycles", name, in_idx, out_idx, cyc);
    endtask

    initial begin
        grid_t g;
        int acc, cyc;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_out_valid", out_valid_a, 0);
        chk("reset_out_row", out_row_a, 0);
        chk("reset_out_last", out_last_a, 0);
        chk("reset_busy", busy_a, 0);
        chk("reset_in_ready", in_ready_a, 0);
        in_valid = 1'b1;
        #1;
        chk("idle_in_ready", in_ready_a, 0);
        in_valid = 1'b0;

        g = '{default: '0}; g[3] = 8'h1C;
        run_gen(g, 0, 0, "blinker");

        g = '{default: '0}; g[2] = 8'h18; g[3] = 8'h18;
        run_gen(g, 0, 0, "block");

        g = '{default: '0}; g[3] = 8'h83;
        run_gen(g, 0, 0, "hwrap");

        g = '{default: '0}; g[0] = 8'h1C;
        run_gen(g, 0, 0, "vdead");

        g = '{default: '0}; g[7] = 8'h1C;
        run_gen(g, 1, 0, "vdead_bot");

        g = '{default: '0}; g[3] = 8'h1C;
        run_gen(g, 1, 0, "blinker_bp");

        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < H; r++) g[r] = W'($urandom);
            run_gen(g, k[0], k[1], $sformatf("rand%0d", k));
        end

        // Abort after 4 accepted rows; rst and start asserted together must leave the block idle.
        g = '{default: '0}; g[3] = 8'h1C;
        @(negedge clk);
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = 0; cyc = 0;
        while (acc < 4 && cyc < 50) begin
            in_valid = 1'b1; in_row = g[acc];
            #1;
            if (in_ready_a) acc++;
            cyc++;
            @(negedge clk);
        end
        chk("abort_rows_accepted", acc, 4);
        chk("abort_busy_before", busy_a, 1);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        chk("abort_out_valid", out_valid_a, 0);
        chk("abort_out_row", out_row_a, 0);
        chk("abort_out_last", out_last_a, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_in_ready", in_ready_a, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("abort_still_idle", busy_a, 0);

        run_gen(g, 0, 1, "restart_noise");
        run_gen(g, 1, 1, "restart_noise_bp");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
